// File: rtl/unpacked_delay_line_pkg.sv
// unpacked_delay_line_pkg
//   Shared definitions for the multi-channel delay line:
//   - tap_width / occ_width : index and counter widths, never narrower than 1 bit
//   - udl_op_e / decode_op  : the four per-edge control operations
package unpacked_delay_line_pkg;

  // The tap bus selects one of DEPTH stages.
  // The 1-bit minimum keeps the port legal when DEPTH is small.
  function automatic int tap_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  // The occupancy counter must be able to represent DEPTH itself,
  // so its width is based on depth+1.
  function automatic int occ_width(input int depth);
    return ($clog2(depth + 1) > 1) ? $clog2(depth + 1) : 1;
  endfunction

  typedef enum logic [1:0] {
    OP_HOLD        = 2'b00,
    OP_SHIFT       = 2'b01,
    OP_FLUSH       = 2'b10,
    OP_FLUSH_SHIFT = 2'b11
  } udl_op_e;

  // Flush and shift are independent controls.
  // Folding them into one operation keeps the valid and occupancy logic
  // readable as a single case statement.
  function automatic udl_op_e decode_op(input logic shift_en, input logic flush);
    return udl_op_e'({flush, shift_en});
  endfunction

endpackage

// File: rtl/unpacked_delay_line_if.sv
// unpacked_delay_line_if
//   Groups the control, data and status signals of the delay line.
//   master : drives shift_en, flush, d_valid, d, tap;
//            observes q, q_valid, occupancy, full, drop
//   slave  : the delay line itself, with the opposite directions
interface unpacked_delay_line_if
  import unpacked_delay_line_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CH    = 2
);

  localparam int TW = tap_width(DEPTH);
  localparam int OW = occ_width(DEPTH);

  logic              shift_en;
  logic              flush;
  logic              d_valid;
  logic [CH*W-1:0]   d;
  logic [TW-1:0]     tap;
  logic [CH*W-1:0]   q;
  logic              q_valid;
  logic [OW-1:0]     occupancy;
  logic              full;
  logic              drop;

  modport master (
    output shift_en, flush, d_valid, d, tap,
    input  q, q_valid, occupancy, full, drop
  );

  modport slave (
    input  shift_en, flush, d_valid, d, tap,
    output q, q_valid, occupancy, full, drop
  );

endinterface

// File: rtl/unpacked_delay_line_lane.sv
// udl_lane
//   Data storage for one channel of the delay line.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   shift_en     : advance every stage by one position
//   d_lane       : word entering stage 0
//   tap          : stage index to present on q_lane (clamped to DEPTH-1)
//   q_lane       : combinational copy of the selected stage
module udl_lane
  import unpacked_delay_line_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int TW    = tap_width(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          shift_en,
  input  logic [W-1:0]  d_lane,
  input  logic [TW-1:0] tap,
  output logic [W-1:0]  q_lane
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [TW-1:0] tap_eff;

  // Stage 0 takes the new word and every later stage takes its predecessor.
  // Data is not qualified by valid; validity is tracked once at the top level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (shift_en) begin
      mem_q[0] <= d_lane;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  // When DEPTH is not a power of two the tap bus can address missing stages.
  // Those indices fall back to the last real stage.
  always_comb begin
    tap_eff = tap;
    if (int'(tap) >= DEPTH) begin
      tap_eff = TW'(DEPTH - 1);
    end
  end

  assign q_lane = mem_q[tap_eff];

endmodule

// File: rtl/unpacked_delay_line.sv
// unpacked_delay_line
//   Parametrised CH-channel, DEPTH-stage delay line with valid tracking.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : shift_en/flush/d_valid/d/tap in;
//                  q/q_valid/occupancy/full/drop out
//   Each channel's data lives in its own udl_lane.
//   The valid bits, occupancy counter and drop pulse are shared by all channels.
module unpacked_delay_line
  import unpacked_delay_line_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CH    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  unpacked_delay_line_if.slave  bus
);

  localparam int TW = tap_width(DEPTH);
  localparam int OW = occ_width(DEPTH);

  logic          vld_q [DEPTH];
  logic          vld_d [DEPTH];
  logic [OW-1:0] occ_q, occ_d;
  logic          drop_q, drop_d;
  logic [OW:0]   occ_sum;
  logic [TW-1:0] tap_eff;
  logic [CH*W-1:0] q_w;
  udl_op_e       op;

  assign op = decode_op(bus.shift_en, bus.flush);

  // One extra bit lets an overflow or underflow show up as a value above
  // DEPTH instead of silently wrapping.
  assign occ_sum = {1'b0, occ_q} + (OW+1)'(bus.d_valid) - (OW+1)'(vld_q[DEPTH-1]);

  // Next-state for the shared control state.
  // A flush wins over the valid word leaving the last stage, so drop stays
  // low on a flush.
  // When flush and shift coincide, only the word entering stage 0 survives.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i];
    end
    occ_d  = occ_q;
    drop_d = 1'b0;
    case (op)
      OP_SHIFT: begin
        vld_d[0] = bus.d_valid;
        for (int i = 1; i < DEPTH; i++) begin
          vld_d[i] = vld_q[i-1];
        end
        occ_d  = occ_sum[OW-1:0];
        drop_d = vld_q[DEPTH-1];
      end
      OP_FLUSH: begin
        for (int i = 0; i < DEPTH; i++) begin
          vld_d[i] = 1'b0;
        end
        occ_d = '0;
      end
      OP_FLUSH_SHIFT: begin
        for (int i = 0; i < DEPTH; i++) begin
          vld_d[i] = 1'b0;
        end
        vld_d[0] = bus.d_valid;
        occ_d    = OW'(bus.d_valid);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i] <= 1'b0;
      end
      occ_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i] <= vld_d[i];
      end
      occ_q  <= occ_d;
      drop_q <= drop_d;
    end
  end

  // The counter can only stay in 0..DEPTH if it tracks the valid bits exactly.
  a_occ_range: assert property (@(posedge clock) disable iff (reset)
    (op == OP_SHIFT) |-> (occ_sum <= (OW+1)'(DEPTH)));

  // Same clamp as inside each lane, so q_valid always matches the stage
  // whose data appears on q.
  always_comb begin
    tap_eff = bus.tap;
    if (int'(bus.tap) >= DEPTH) begin
      tap_eff = TW'(DEPTH - 1);
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    udl_lane #(
      .W     (W),
      .DEPTH (DEPTH),
      .TW    (TW)
    ) u_lane (
      .clock    (clock),
      .reset    (reset),
      .shift_en (bus.shift_en),
      .d_lane   (bus.d[c*W +: W]),
      .tap      (bus.tap),
      .q_lane   (q_w[c*W +: W])
    );
  end

  assign bus.q         = q_w;
  assign bus.q_valid   = vld_q[tap_eff];
  assign bus.occupancy = occ_q;
  assign bus.full      = (occ_q == OW'(DEPTH));
  assign bus.drop      = drop_q;

endmodule

// File: tb/tb_unpacked_delay_line.sv
// tb_unpacked_delay_line
//   Exercises a DEPTH=4 instance against a queue-based reference model using
//   directed and random steps.
//   Also exercises a DEPTH=3 instance for tap clamping.
module tb_unpacked_delay_line;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int CH    = 2;
  localparam int DW    = CH * W;

  typedef struct {
    logic [DW-1:0] data;
    logic          vld;
  } entry_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #10 clock = ~clock;

  unpacked_delay_line_if #(.W(W), .DEPTH(DEPTH), .CH(CH)) busA ();
  unpacked_delay_line_if #(.W(W), .DEPTH(3),     .CH(CH)) busB ();

  unpacked_delay_line #(.W(W), .DEPTH(DEPTH), .CH(CH)) dutA (
    .clock (clock),
    .reset (reset),
    .bus   (busA)
  );

  unpacked_delay_line #(.W(W), .DEPTH(3), .CH(CH)) dutB (
    .clock (clock),
    .reset (reset),
    .bus   (busB)
  );

  int     testCount = 0;
  int     failCount = 0;
  entry_t mq[$];
  logic   mDrop;

  // Compares one observed value against the expected value.
  // On a miss it counts the failure and reports both values.
  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a queue indexed by stage, with stage 0 the newest word.
  task automatic modelReset();
    entry_t e;
    e.data = '0;
    e.vld  = 1'b0;
    mq.delete();
    for (int i = 0; i < DEPTH; i++) mq.push_back(e);
    mDrop = 1'b0;
  endtask

  function automatic int modelOcc();
    int n = 0;
    foreach (mq[i]) if (mq[i].vld) n++;
    return n;
  endfunction

  task automatic modelStep(input logic sh, input logic fl, input logic dv, input logic [DW-1:0] dd);
    entry_t e;
    entry_t old;
    mDrop = 1'b0;
    if (sh) begin
      e.data = dd;
      e.vld  = dv;
      mq.push_front(e);
      old = mq.pop_back();
      mDrop = old.vld && !fl;
      if (fl) for (int i = 1; i < DEPTH; i++) mq[i].vld = 1'b0;
    end else if (fl) begin
      for (int i = 0; i < DEPTH; i++) mq[i].vld = 1'b0;
    end
  endtask

  // Drives one clock edge on dutA and advances the model alongside it.
  task automatic applyStimulus(input logic sh, input logic fl, input logic dv, input logic [DW-1:0] dd);
    busA.shift_en = sh;
    busA.flush    = fl;
    busA.d_valid  = dv;
    busA.d        = dd;
    @(posedge clock);
    modelStep(sh, fl, dv, dd);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, "/occupancy"}, 64'(busA.occupancy), 64'(modelOcc()));
    checkVal({tag, "/full"},      64'(busA.full),      64'(modelOcc() == DEPTH));
    checkVal({tag, "/drop"},      64'(busA.drop),      64'(mDrop));
    for (int t = 0; t < DEPTH; t++) begin
      busA.tap = 2'(t);
      #1;
      checkVal($sformatf("%s/q[tap%0d]", tag, t),       64'(busA.q),       64'(mq[t].data));
      checkVal($sformatf("%s/q_valid[tap%0d]", tag, t), 64'(busA.q_valid), 64'(mq[t].vld));
    end
  endtask

  task automatic checkTap(input string tag, input int t, input logic [DW-1:0] expQ, input logic expV);
    busA.tap = 2'(t);
    #1;
    checkVal($sformatf("%s/q[tap%0d]", tag, t),       64'(busA.q),       64'(expQ));
    checkVal($sformatf("%s/q_valid[tap%0d]", tag, t), 64'(busA.q_valid), 64'(expV));
  endtask

  logic [DW-1:0] saved [DEPTH];
  logic          rsh, rfl, rdv;
  logic [DW-1:0] rdd;

  initial begin
    busA.shift_en = 1'b0; busA.flush = 1'b0; busA.d_valid = 1'b0; busA.d = '0; busA.tap = '0;
    busB.shift_en = 1'b0; busB.flush = 1'b0; busB.d_valid = 1'b0; busB.d = '0; busB.tap = '0;
    modelReset();

    // Reset state while reset is held.
    #25;
    checkVal("rst/occupancy", 64'(busA.occupancy), 64'd0);
    checkVal("rst/q_valid",   64'(busA.q_valid),   64'd0);
    checkVal("rst/full",      64'(busA.full),      64'd0);
    checkVal("rst/q",         64'(busA.q),         64'd0);
    checkVal("rst/drop",      64'(busA.drop),      64'd0);
    reset = 1'b0;

    // Reset in the middle of operation, asserted between clock edges.
    applyStimulus(1, 0, 1, 16'hA1B1); checkOutput("pre");
    applyStimulus(1, 0, 1, 16'hA2B2); checkOutput("pre");
    applyStimulus(1, 0, 1, 16'hA3B3); checkOutput("pre");
    busA.tap = 2'd1;
    reset = 1'b1;
    #1;
    checkVal("midrst/occupancy", 64'(busA.occupancy), 64'd0);
    checkVal("midrst/q_valid",   64'(busA.q_valid),   64'd0);
    checkVal("midrst/full",      64'(busA.full),      64'd0);
    checkVal("midrst/q",         64'(busA.q),         64'd0);
    checkVal("midrst/drop",      64'(busA.drop),      64'd0);
    busA.shift_en = 1'b0;
    @(posedge clock);
    #3;
    reset = 1'b0;
    modelReset();

    // Fill with four valid words.
    applyStimulus(1, 0, 1, 16'h1101); checkOutput("fill");
    applyStimulus(1, 0, 1, 16'h2202); checkOutput("fill");
    applyStimulus(1, 0, 1, 16'h3303); checkOutput("fill");
    applyStimulus(1, 0, 1, 16'h4404); checkOutput("fill");
    checkVal("fill/occ4", 64'(busA.occupancy), 64'd4);
    checkVal("fill/full", 64'(busA.full),      64'd1);
    checkTap("fill", 0, 16'h4404, 1'b1);
    checkTap("fill", 3, 16'h1101, 1'b1);

    // A shift with an invalid word pushes the oldest valid word out.
    applyStimulus(1, 0, 0, 16'h0000); checkOutput("out");
    checkVal("out/drop", 64'(busA.drop),      64'd1);
    checkVal("out/occ3", 64'(busA.occupancy), 64'd3);
    checkVal("out/full", 64'(busA.full),      64'd0);
    checkTap("out", 3, 16'h2202, 1'b1);
    applyStimulus(0, 0, 0, 16'h0000); checkOutput("hold");
    checkVal("hold/drop_once", 64'(busA.drop), 64'd0);

    // Alternating valid and invalid words leave holes in the valid pattern.
    applyStimulus(1, 0, 1, 16'h5505); checkOutput("hole");
    applyStimulus(1, 0, 0, 16'h6606); checkOutput("hole");
    applyStimulus(1, 0, 1, 16'h7707); checkOutput("hole");
    applyStimulus(1, 0, 0, 16'h8808); checkOutput("hole");
    checkVal("hole/occ2", 64'(busA.occupancy), 64'd2);
    checkTap("hole", 3, 16'h5505, 1'b1);
    checkTap("hole", 2, 16'h6606, 1'b0);
    checkTap("hole", 1, 16'h7707, 1'b1);
    checkTap("hole", 0, 16'h8808, 1'b0);

    // Flush alone clears validity but keeps the data.
    for (int k = 1; k <= DEPTH; k++) begin
      applyStimulus(1, 0, 1, DW'(16'h0101 * k));
      checkOutput("refill");
    end
    for (int t = 0; t < DEPTH; t++) saved[t] = mq[t].data;
    applyStimulus(0, 1, 0, 16'h0000); checkOutput("flush");
    checkVal("flush/occ0", 64'(busA.occupancy), 64'd0);
    for (int t = 0; t < DEPTH; t++) checkTap("flush", t, saved[t], 1'b0);

    // Flush together with a shift keeps only the incoming word.
    applyStimulus(1, 1, 1, 16'hAA55); checkOutput("fshift");
    checkVal("fshift/occ1", 64'(busA.occupancy), 64'd1);
    checkVal("fshift/drop", 64'(busA.drop),      64'd0);
    checkTap("fshift", 0, 16'hAA55, 1'b1);

    // Flush with a shift while a valid word sits in the last stage.
    applyStimulus(1, 0, 1, 16'h1234); checkOutput("fshift2");
    applyStimulus(1, 0, 1, 16'h5678); checkOutput("fshift2");
    applyStimulus(1, 0, 1, 16'h9ABC); checkOutput("fshift2");
    applyStimulus(1, 1, 0, 16'hDEF0); checkOutput("fshift2");
    checkVal("fshift2/drop", 64'(busA.drop),      64'd0);
    checkVal("fshift2/occ0", 64'(busA.occupancy), 64'd0);

    // Random mix of shift, hold and flush.
    for (int n = 0; n < 300; n++) begin
      rsh = ($urandom_range(0, 9) < 7);
      rfl = ($urandom_range(0, 9) == 0);
      rdv = 1'($urandom_range(0, 1));
      rdd = DW'($urandom);
      applyStimulus(rsh, rfl, rdv, rdd);
      checkOutput("rand");
    end
    busA.shift_en = 1'b0;
    busA.flush    = 1'b0;

    // Tap clamp on the DEPTH=3 instance.
    busB.d_valid  = 1'b1;
    busB.shift_en = 1'b1;
    busB.d = 16'h0A0B; @(posedge clock); #1;
    busB.d = 16'h1C1D; @(posedge clock); #1;
    busB.d = 16'h2E2F; @(posedge clock); #1;
    busB.shift_en = 1'b0;
    busB.tap = 2'd3;
    #1;
    checkVal("clamp/q[tap3]",       64'(busB.q),         64'h0A0B);
    checkVal("clamp/q_valid[tap3]", 64'(busB.q_valid),   64'd1);
    checkVal("clamp/occupancy",     64'(busB.occupancy), 64'd3);
    checkVal("clamp/full",          64'(busB.full),      64'd1);
    busB.tap = 2'd2;
    #1;
    checkVal("clamp/q[tap2]", 64'(busB.q), 64'h0A0B);
    busB.tap = 2'd0;
    #1;
    checkVal("clamp/q[tap0]", 64'(busB.q), 64'h2E2F);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/unpacked_delay_line.md
Name: unpacked_delay_line

Overview:
Parametrised multi-channel delay line whose storage is declared as unpacked arrays sized by parameter, e.g. mem [CH][DEPTH] and vld [DEPTH]. It generalises the fixed two-entry array block to configurable width, depth and channel count. It adds shift enable, valid tracking, flush, a selectable output tap, an occupancy counter and a drop indication. It is a TMR-triplication test vehicle and a reusable small pipeline buffer.

Parameters:
W, 8, data width per channel (>=1)
DEPTH, 4, number of stages (>=2; need not be a power of 2)
CH, 2, number of parallel channels sharing control (>=1)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
shift_en  input  1  advance all stages by one
flush  input  1  invalidate all stages
d_valid  input  1  valid tag for the incoming word
d  input  CH*W  incoming word; channel c occupies bits [c*W +: W]
tap  input  TW=$clog2(DEPTH)  stage index driven to q
q  output  CH*W  stage[tap] data, all channels
q_valid  output  1  vld[tap]
occupancy  output  OW=$clog2(DEPTH+1)  number of valid stages
full  output  1  occupancy == DEPTH
drop  output  1  one-cycle pulse: a valid word left the last stage

Behaviour:
- Reset (asynchronous assert, synchronous to clock on release): all mem entries = 0, all vld = 0, occupancy = 0, drop = 0. Combinationally this gives q = 0, q_valid = 0, full = 0.
- Shift (shift_en=1) on a rising edge, for every channel c:
  - mem[c][0] <= d[c].
  - mem[c][i] <= mem[c][i-1] for i = 1..DEPTH-1.
  - vld[0] <= d_valid; vld[i] <= vld[i-1].
- Hold (shift_en=0, flush=0): all state is unchanged; drop <= 0.
- Flush only (flush=1, shift_en=0): all vld <= 0, occupancy <= 0, drop <= 0. Data in mem is unchanged.
- Flush with shift (flush=1, shift_en=1):
  - mem shifts as normal.
  - vld[0] <= d_valid; vld[1..DEPTH-1] <= 0.
  - occupancy <= d_valid; drop <= 0.
- Occupancy on a shift without flush: occupancy <= occupancy + d_valid - vld[DEPTH-1]. Compute at OW+1 bits. The result can never exceed DEPTH or go below 0; assert this in simulation.
- drop on a shift without flush: drop <= vld[DEPTH-1]. drop is registered and high for exactly one cycle per departing valid word.
- Output path:
  - q and q_valid are combinational from the registered stage selected by tap. No extra latency.
  - A word presented with shift_en at edge n is visible at tap=k after edge n+k.
- tap >= DEPTH (possible when DEPTH is not a power of 2) clamps to DEPTH-1.
- full is combinational from occupancy.
- Channels share vld, occupancy and drop; only data is per channel.

Decomposition:
- Package unpacked_delay_line_pkg: width helper functions for TW and OW (clog2 with a minimum of 1).
- Sub-module udl_lane, one per channel, generated CH times:
  - Contents: storage mem [DEPTH] of W bits, the shift logic and the tap multiplexer with clamp.
  - Ports: clock, reset, shift_en, d_lane, tap, q_lane.
- The top level owns vld [DEPTH], the occupancy counter, drop, full and the channel packing.

Test Plan:
- Reset mid-operation: fill 3 valid words, then assert reset asynchronously between edges -> occupancy, q_valid, full and q go to 0 immediately; drop stays 0.
- Fill (W=8, DEPTH=4, CH=2): shift in d={8'h11,8'h01}..{8'h44,8'h04}, all valid, over 4 edges -> occupancy=4, full=1; tap=0 gives q={8'h44,8'h04}; tap=3 gives q={8'h11,8'h01}, q_valid=1.
- Full shift-out: continue with one shift and d_valid=0 -> drop=1 for exactly one cycle, occupancy=3, full=0; tap=3 now shows {8'h22,8'h02}.
- Hole: valid/invalid alternating input over 4 shifts -> occupancy=2; q_valid follows the vld pattern per tap (1,0,1,0 from tap 3..0).
- Flush: flush alone with occupancy=4 -> occupancy=0, q_valid=0 for every tap, q data unchanged. Flush+shift with d_valid=1, d={8'hAA,8'h55} -> occupancy=1, tap=0 gives q={8'hAA,8'h55}, q_valid=1; drop=0.
- Tap clamp (DEPTH=3): fill 3 words, apply tap=3 -> q equals the tap=2 output, q_valid=1.
